// File: rtl/ysyx_22040175_mem_resp_pkg.sv
// ysyx_22040175_mem_resp_pkg: shared constants, FSM encoding and lane-mask helper for the memory responder
package ysyx_22040175_mem_resp_pkg;
  localparam int MR_DATA_W = 64;
  localparam int MR_MASK_W = MR_DATA_W / 8;
  localparam logic [31:0] MR_BASE = 32'h8000_0000;
  typedef enum logic [1:0] {
    MR_IDLE = 2'd0,
    MR_WAIT = 2'd1,
    MR_RESP = 2'd2
  } mr_state_e;
  function automatic logic [MR_DATA_W-1:0] mr_lane_mask(input logic [MR_MASK_W-1:0] m);
    logic [MR_DATA_W-1:0] bm;
    for (int i = 0; i < MR_MASK_W; i++) bm[8*i+:8] = {8{m[i]}};
    return bm;
  endfunction
endpackage

// File: rtl/ysyx_22040175_sram_bytemask.sv
// ysyx_22040175_sram_bytemask: single-port synchronous array with byte-lane write enables and registered read
module ysyx_22040175_sram_bytemask
  import ysyx_22040175_mem_resp_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [MR_DATA_W-1:0] wdata,
  input  logic [MR_MASK_W-1:0] wmask,
  output logic [MR_DATA_W-1:0] rdata
);
  logic [MR_DATA_W-1:0] mem [DEPTH];
  logic [MR_DATA_W-1:0] bm;
  assign bm = mr_lane_mask(wmask);
  // one access per enabled cycle: merge enabled lanes on write, capture the word on read
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= (mem[addr] & ~bm) | (wdata & bm);
      else rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/ysyx_22040175_mem_resp.sv
// ysyx_22040175_mem_resp: latency-modelled valid/ready memory responder in front of a byte-masked SRAM
module ysyx_22040175_mem_resp
  import ysyx_22040175_mem_resp_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = MR_DATA_W,
  parameter int DEPTH = 4096,
  parameter logic [ADDR_W-1:0] BASE = ADDR_W'(MR_BASE),
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [7:0]        req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH);
  mr_state_e state, nxt;
  logic [3:0] cnt;
  logic wr_q;
  logic [ADDR_W-1:0] addr_q, off;
  logic [DATA_W-1:0] wdata_q, sram_q;
  logic [7:0] wmask_q;
  logic ok, req_fire, access;
  assign off = addr_q - BASE;
  assign ok = (addr_q >= BASE) && ((off >> 3) < ADDR_W'(DEPTH));
  // next state and outputs; ready is gated by rst_n so it stays low while reset is held
  always_comb begin
    req_ready = rst_n && (state == MR_IDLE);
    req_fire = req_valid && req_ready;
    access = (state == MR_WAIT) && (cnt == 4'd0);
    resp_valid = state == MR_RESP;
    resp_err = resp_valid && !ok;
    resp_rdata = (resp_valid && !wr_q && ok) ? sram_q : '0;
    busy = state != MR_IDLE;
    nxt = (req_fire) ? MR_WAIT :
          (access) ? MR_RESP :
          (resp_valid && resp_ready) ? MR_IDLE : state;
  end
  // state, latency counter and the request latched at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MR_IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state <= nxt;
      if (req_fire) begin
        cnt <= 4'(LATENCY - 1);
        wr_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        wmask_q <= req_wmask;
      end else if (state == MR_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  ysyx_22040175_sram_bytemask #(.DEPTH(DEPTH)) u_sram (
    .clk(clk),
    .en(access && ok),
    .we(wr_q),
    .addr(IW'(off >> 3)),
    .wdata(wdata_q),
    .wmask(wmask_q),
    .rdata(sram_q)
  );
endmodule

// File: tb/tb_ysyx_22040175_mem_resp.sv
// tb_ysyx_22040175_mem_resp: randomized self-checking bench against a word-level memory model
module tb_ysyx_22040175_mem_resp;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam longint unsigned TOP = 64'h8000_0000 + 4096 * 8;
  logic clk = 0;
  logic rst_n;
  logic req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err, busy;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, resp_rdata;
  logic [7:0] req_wmask;
  logic b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata, b_resp_rdata;
  logic [7:0] b_req_wmask;
  int n_vec = 0, n_err = 0;
  logic [63:0] mdl [int];
  always #5 clk = ~clk;
  ysyx_22040175_mem_resp #(.LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy)
  );
  ysyx_22040175_mem_resp #(.LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wmask(b_req_wmask),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // one transaction on the LATENCY=2 responder, checked against the word model
  task automatic xact(input bit w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m, input int hold);
    longint unsigned au = a;
    bit inr = au >= 64'h8000_0000 && au < TOP;
    int k = int'((a - BASE) >> 3);
    bit known = 0;
    logic [63:0] e_rd = 0, rd, nw;
    int g = 0, lat = 0;
    if (inr && w) begin
      if (mdl.exists(k) || m == 8'hFF) begin
        nw = mdl.exists(k) ? mdl[k] : 64'h0;
        for (int i = 0; i < 8; i++) if (m[i]) nw[8*i+:8] = d[8*i+:8];
        mdl[k] = nw;
      end
    end else if (inr) begin
      known = mdl.exists(k);
      if (known) e_rd = mdl[k];
    end
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    chk("accept_timeout", 64'(g < 50), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("ready_in_wait", 64'(req_ready), 64'd0);
    chk("busy_in_wait", 64'(busy), 64'd1);
    while (!resp_valid && lat < 50) begin lat++; @(negedge clk); end
    chk("latency", 64'(lat), 64'd2);
    rd = resp_rdata;
    chk("err", 64'(resp_err), 64'(!inr));
    if (w || !inr || known) chk("rdata", rd, e_rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(resp_valid), 64'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("post_valid", 64'(resp_valid), 64'd0);
    chk("post_ready", 64'(req_ready), 64'd1);
    chk("post_busy", 64'(busy), 64'd0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bit bw[4] = '{1, 1, 0, 0};
    logic [31:0] ba[4] = '{BASE, BASE + 8, BASE, BASE + 8};
    logic [63:0] bd[4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 0, 0};
    logic [63:0] be[4] = '{0, 0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    int i = 0, r = 0, last = -1;
    bit pr;
    logic [31:0] a;
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; resp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_wmask = 8'hFF; b_resp_ready = 1;
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    rst_n = 1;
    #1;
    chk("rel_ready", 64'(req_ready), 64'd1);
    chk("rel_valid", 64'(resp_valid), 64'd0);
    chk("rel_rdata", resp_rdata, 64'd0);
    chk("rel_err", 64'(resp_err), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    @(negedge clk);
    b_req_valid = 1; b_req_write = bw[0]; b_req_addr = ba[0]; b_req_wdata = bd[0];
    pr = b_req_ready;
    for (int c = 0; c < 80 && r < 4; c++) begin
      @(negedge clk);
      if (pr) begin
        if (last >= 0) chk("b2b_gap", 64'(c - last), 64'd3);
        last = c;
        i++;
        if (i < 4) begin b_req_write = bw[i]; b_req_addr = ba[i]; b_req_wdata = bd[i]; end
        else b_req_valid = 0;
      end
      if (b_resp_valid) begin chk("b2b_data", b_resp_rdata, be[r]); r++; end
      pr = b_req_valid && b_req_ready;
    end
    chk("b2b_count", 64'(r), 64'd4);
    for (int k = 0; k < 8; k++) xact(1, BASE + 32'(k * 8), {$urandom, $urandom}, 8'hFF, 0);
    xact(1, BASE + 8, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);
    xact(0, BASE + 8, 0, 0, 0);
    xact(1, BASE + 16, 0, 8'hFF, 0);
    xact(1, BASE + 16, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
    xact(0, BASE + 16, 0, 0, 0);
    chk("masked_word", mdl[2], 64'h0000_0000_FFFF_FFFF);
    xact(1, BASE + 24, 64'hDEAD_BEEF_0000_0000, 8'h00, 0);
    xact(0, 32'h7FFF_FFF8, 0, 0, 0);
    xact(0, 32'h8000_8000, 0, 0, 0);
    xact(1, 32'h8000_8000, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0);
    for (int k = 0; k < 8; k++) xact(0, BASE + 32'(k * 8), 0, 0, 0);
    xact(0, BASE + 24, 0, 0, 5);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = BASE; req_wdata = 64'hCAFE_F00D_CAFE_F00D; req_wmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_valid", 64'(resp_valid), 64'd0);
    chk("arst_rdata", resp_rdata, 64'd0);
    chk("arst_err", 64'(resp_err), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("arst_rel_ready", 64'(req_ready), 64'd1);
    xact(0, BASE, 0, 0, 0);
    for (int t = 0; t < 40; t++) begin
      if ($urandom % 8 == 0)
        a = ($urandom % 2) ? 32'h8000_8000 + 32'($urandom % 1024) * 8 : $urandom_range(32'h7FFF_FFFF, 0);
      else
        a = BASE + 32'($urandom % 8) * 8 + 32'($urandom % 8);
      xact(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), int'($urandom % 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
